// File: rtl/serial_deserializer.sv
// serial_deserializer: turns edge-detector strobes plus a synchronized serial line into
// DATA_WIDTH-bit words, presented on a one-entry valid/ready holding register.
// A frame gate discards partial words. An inactivity timeout also discards them and
// reports the discard with a one-cycle pulse.
module serial_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 1200
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  sample_strb,
  input  logic                  data_in,
  input  logic                  frame_active,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         idle_cnt;
  logic                  take_bit;
  logic                  word_done;
  logic                  idle_hit;
  logic                  load_word;

  // Decode this cycle's events. A strobe counts only once the registered state has seen
  // the frame open, and only while the frame is still open. Closing the frame therefore
  // takes priority over a coincident strobe.
  always_comb begin
    take_bit  = (state == SHIFT) && frame_active && sample_strb;
    if (MSB_FIRST != 0) begin
      shifted = {shift_reg[DATA_WIDTH-2:0], data_in};
    end else begin
      shifted = {data_in, shift_reg[DATA_WIDTH-1:1]};
    end
    word_done = take_bit && (bit_cnt == LAST_BIT);
    idle_hit  = TIMEOUT_EN && frame_active && !take_bit && (bit_cnt != '0) &&
                (idle_cnt == IDLE_LAST);
    load_word = word_done && (!data_valid || data_ready);
  end

  // Frame state, shift datapath, inactivity counter, holding register and status pulses.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state   <= frame_active ? SHIFT : IDLE;
      overrun <= word_done && data_valid && !data_ready;
      timeout <= idle_hit;

      if (!frame_active) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        idle_cnt  <= '0;
        busy      <= 1'b0;
      end else if (take_bit) begin
        shift_reg <= shifted;
        idle_cnt  <= '0;
        if (word_done) begin
          bit_cnt <= '0;
          busy    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          busy    <= 1'b1;
        end
      end else if (idle_hit) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        idle_cnt  <= '0;
        busy      <= 1'b0;
      end else if (TIMEOUT_EN && (bit_cnt != '0)) begin
        idle_cnt <= idle_cnt + IW'(1);
      end

      if (load_word) begin
        data_out   <= shifted;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: drives an MSB-first and an LSB-first instance from the same
// stimulus. Expected words are queued per instance when issued. A monitor pops a queue
// entry and compares it whenever an instance hands a word over.
module tb_serial_deserializer;

  logic       sys_clk;
  logic       rst;
  logic       sample_strb;
  logic       data_in;
  logic       frame_active;
  logic       data_ready;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l;
  logic       ov_m, ov_l;
  logic       to_m, to_l;
  logic       busy_m, busy_l;

  int total = 0;
  int bad   = 0;
  int ov_cnt_m = 0, ov_cnt_l = 0;
  int to_cnt_m = 0, to_cnt_l = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  serial_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .TIMEOUT_CYCLES(1200)) u_msb (
    .sys_clk(sys_clk), .rst(rst), .sample_strb(sample_strb), .data_in(data_in),
    .frame_active(frame_active), .data_out(dout_m), .data_valid(valid_m),
    .data_ready(data_ready), .overrun(ov_m), .timeout(to_m), .busy(busy_m)
  );

  serial_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .TIMEOUT_CYCLES(1200)) u_lsb (
    .sys_clk(sys_clk), .rst(rst), .sample_strb(sample_strb), .data_in(data_in),
    .frame_active(frame_active), .data_out(dout_l), .data_valid(valid_l),
    .data_ready(data_ready), .overrun(ov_l), .timeout(to_l), .busy(busy_l)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Stops a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sends the first n bits of w, starting at w[7], as back-to-back strobes.
  task automatic apply_stimulus(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sample_strb = 1'b1;
      data_in     = w[7-i];
      @(posedge sys_clk);
      #1;
    end
    sample_strb = 1'b0;
    data_in     = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] exp_m, input logic [7:0] exp_l);
    q_m.push_back(exp_m);
    q_l.push_back(exp_l);
  endtask

  // Scoreboard monitor: each handshake is checked against the oldest queued word.
  // Overrun and timeout pulses are also counted here.
  always @(negedge sys_clk) begin
    if (rst) begin
      if (ov_m) ov_cnt_m++;
      if (ov_l) ov_cnt_l++;
      if (to_m) to_cnt_m++;
      if (to_l) to_cnt_l++;
      if (valid_m && data_ready) begin
        if (q_m.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word_msb: got=%0h expected=none", dout_m);
        end else begin
          check_output("word_msb", {24'd0, dout_m}, {24'd0, q_m.pop_front()});
        end
      end
      if (valid_l && data_ready) begin
        if (q_l.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word_lsb: got=%0h expected=none", dout_l);
        end else begin
          check_output("word_lsb", {24'd0, dout_l}, {24'd0, q_l.pop_front()});
        end
      end
    end
  end

  initial begin
    int seen;
    rst          = 1'b0;
    sample_strb  = 1'b0;
    data_in      = 1'b0;
    frame_active = 1'b0;
    data_ready   = 1'b1;

    // Outputs while held in reset.
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check_output("rst_valid_m", valid_m, 0);
    check_output("rst_dout_m", dout_m, 0);
    check_output("rst_busy_m", busy_m, 0);
    check_output("rst_ov_m", ov_m, 0);
    check_output("rst_to_m", to_m, 0);
    check_output("rst_valid_l", valid_l, 0);
    @(posedge sys_clk);
    #1;
    rst          = 1'b1;
    frame_active = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    // 1: 0xA5. The word must appear exactly one cycle after the 8th strobe.
    push_word(8'hA5, 8'hA5);
    apply_stimulus(8'hA5, 7);
    sample_strb = 1'b1;
    data_in     = 1'b1;
    @(negedge sys_clk);
    check_output("t1_valid_before_edge", valid_m, 0);
    @(posedge sys_clk);
    #1;
    sample_strb = 1'b0;
    @(negedge sys_clk);
    check_output("t1_valid_after_edge", valid_m, 1);
    check_output("t1_dout_m", dout_m, 8'hA5);
    @(posedge sys_clk);
    #1;

    // 2: bits 1,1,0,0,0,0,0,0 give 0xC0 MSB-first and 0x03 LSB-first.
    push_word(8'hC0, 8'h03);
    apply_stimulus(8'hC0, 8);
    repeat (2) @(posedge sys_clk);
    #1;

    // 3: Consumer stalled. The second word overruns and the first word is kept.
    data_ready = 1'b0;
    push_word(8'h11, 8'h88);
    apply_stimulus(8'h11, 8);
    apply_stimulus(8'h22, 7);
    sample_strb = 1'b1;
    data_in     = 1'b0;
    @(posedge sys_clk);
    #1;
    sample_strb = 1'b0;
    @(negedge sys_clk);
    check_output("t3_overrun_m", ov_m, 1);
    check_output("t3_overrun_l", ov_l, 1);
    check_output("t3_hold_m", dout_m, 8'h11);
    check_output("t3_hold_l", dout_l, 8'h88);
    @(posedge sys_clk);
    #1;
    data_ready = 1'b1;
    @(negedge sys_clk);
    check_output("t3_overrun_single", ov_m, 0);
    @(posedge sys_clk);
    #1;
    data_ready = 1'b0;
    @(negedge sys_clk);
    check_output("t3_valid_drop", valid_m, 0);
    @(posedge sys_clk);
    #1;
    data_ready = 1'b1;

    // 4: A partial word times out after 1200 idle cycles. The next word has no stale bits.
    apply_stimulus(8'hA0, 3);
    @(negedge sys_clk);
    check_output("t4_busy_partial", busy_m, 1);
    seen = 0;
    for (int i = 1; i <= 1300; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (to_m) begin
        seen = i;
        break;
      end
    end
    check_output("t4_timeout_latency", seen, 1200);
    check_output("t4_timeout_l", to_l, 1);
    check_output("t4_busy_cleared", busy_m, 0);
    @(negedge sys_clk);
    check_output("t4_timeout_single", to_m, 0);
    @(posedge sys_clk);
    #1;
    push_word(8'h5A, 8'h5A);
    apply_stimulus(8'h5A, 8);
    repeat (2) @(posedge sys_clk);
    #1;

    // 5: The frame closes with a coincident strobe. Strobes while the frame is closed are ignored.
    apply_stimulus(8'hF8, 5);
    frame_active = 1'b0;
    sample_strb  = 1'b1;
    data_in      = 1'b1;
    @(posedge sys_clk);
    #1;
    sample_strb = 1'b0;
    @(negedge sys_clk);
    check_output("t5_busy_m", busy_m, 0);
    check_output("t5_busy_l", busy_l, 0);
    check_output("t5_no_overrun", ov_m, 0);
    check_output("t5_no_timeout", to_m, 0);
    check_output("t5_no_word", valid_m, 0);
    @(posedge sys_clk);
    #1;
    apply_stimulus(8'hFF, 8);
    @(negedge sys_clk);
    check_output("t5_idle_no_word", valid_m, 0);
    check_output("t5_idle_not_busy", busy_m, 0);
    @(posedge sys_clk);
    #1;
    frame_active = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;

    // 6: Asynchronous reset with a word held and a partial word in flight.
    data_ready = 1'b0;
    apply_stimulus(8'h3C, 8);
    apply_stimulus(8'hF0, 4);
    @(negedge sys_clk);
    check_output("t6_pre_valid", valid_m, 1);
    check_output("t6_pre_busy", busy_m, 1);
    check_output("t6_pre_dout", dout_m, 8'h3C);
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_async_valid_m", valid_m, 0);
    check_output("t6_async_dout_m", dout_m, 0);
    check_output("t6_async_busy_m", busy_m, 0);
    check_output("t6_async_valid_l", valid_l, 0);
    check_output("t6_async_dout_l", dout_l, 0);
    check_output("t6_async_busy_l", busy_l, 0);
    @(posedge sys_clk);
    #1;
    rst        = 1'b1;
    data_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    push_word(8'hFF, 8'hFF);
    apply_stimulus(8'hFF, 8);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);

    // Wrap-up: every queued word was delivered and each pulse fired exactly once.
    check_output("end_queue_m", q_m.size(), 0);
    check_output("end_queue_l", q_l.size(), 0);
    check_output("end_overruns_m", ov_cnt_m, 1);
    check_output("end_overruns_l", ov_cnt_l, 1);
    check_output("end_timeouts_m", to_cnt_m, 1);
    check_output("end_timeouts_l", to_cnt_l, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
